// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Mode encodings and the shift-counter width helper.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: 4:1 next-state mux + DFF.
// Ports: Clock, Reset (sync, high), Enable, Mode, lo/hi neighbours, d, q.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Mode,
    input  logic       lo,
    input  logic       hi,
    input  logic       d,
    output logic       q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q <= 1'b0;
        end else if (Enable) begin
            unique case (Mode)
                MODE_HOLD: q <= q;
                MODE_UP:   q <= lo;
                MODE_DN:   q <= hi;
                MODE_LOAD: q <= d;
            endcase
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with saturating shift counter.
// Ports: Clock, Reset, Enable, Mode, SI_UP, SI_DN, D -> Q, SO_UP, SO_DN, ShiftCnt, Done.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic [1:0]                    Mode,
    input  logic                          SI_UP,
    input  logic                          SI_DN,
    input  logic [WIDTH-1:0]              D,
    output logic [WIDTH-1:0]              Q,
    output logic                          SO_UP,
    output logic                          SO_DN,
    output logic [cnt_width(WIDTH)-1:0]   ShiftCnt,
    output logic                          Done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] up_src;
    logic [WIDTH-1:0] dn_src;

    // Each bit's lower neighbour feeds it on shift up, upper on shift down;
    // the serial inputs stand in for the missing neighbours at the ends.
    assign up_src = {q_r[WIDTH-2:0], SI_UP};
    assign dn_src = {SI_DN, q_r[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .Enable (Enable),
            .Mode   (Mode),
            .lo     (up_src[i]),
            .hi     (dn_src[i]),
            .d      (D[i]),
            .q      (q_r[i])
        );
    end

    assign Q     = q_r;
    assign SO_UP = q_r[WIDTH-1];
    assign SO_DN = q_r[0];

    // Done is updated alongside the count so it rises on the edge
    // that brings ShiftCnt to WIDTH, and stays up once saturated.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ShiftCnt <= '0;
            Done     <= 1'b0;
        end else if (Enable) begin
            unique case (Mode)
                MODE_HOLD: begin
                    ShiftCnt <= ShiftCnt;
                    Done     <= Done;
                end
                MODE_UP, MODE_DN: begin
                    if (ShiftCnt < FULL) begin
                        ShiftCnt <= ShiftCnt + 1'b1;
                    end
                    Done <= (ShiftCnt >= FULL - 1'b1);
                end
                MODE_LOAD: begin
                    ShiftCnt <= '0;
                    Done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH = 6.
// Each task drives one scenario and checks against hand-computed values.
module tb_univ_shift_reg;

    logic       Clock;
    logic       Reset;
    logic       Enable;
    logic [1:0] Mode;
    logic       SI_UP;
    logic       SI_DN;
    logic [5:0] D;
    logic [5:0] Q;
    logic       SO_UP;
    logic       SO_DN;
    logic [2:0] ShiftCnt;
    logic       Done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(6)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .Mode     (Mode),
        .SI_UP    (SI_UP),
        .SI_DN    (SI_DN),
        .D        (D),
        .Q        (Q),
        .SO_UP    (SO_UP),
        .SO_DN    (SO_DN),
        .ShiftCnt (ShiftCnt),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge; outputs are read 1 time unit afterwards.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; Mode = 2'b11; D = 6'h3F;
        tick();
        Reset = 1'b0; Mode = 2'b00;
        checks++;
        if (Q !== 6'h00) begin
            errors++; $display("FAIL reset_q: got %h want %h", Q, 6'h00);
        end
        checks++;
        if (ShiftCnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", ShiftCnt);
        end
        checks++;
        if (Done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", Done);
        end
        checks++;
        if ({SO_UP, SO_DN} !== 2'b00) begin
            errors++; $display("FAIL reset_so: got %b want 00", {SO_UP, SO_DN});
        end
    endtask

    task automatic test_serial_up();
        logic [5:0] pat;
        pat = 6'b101100;
        Mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            SI_UP = pat[5-i];
            tick();
            checks++;
            if (ShiftCnt !== 3'(i + 1)) begin
                errors++; $display("FAIL up_cnt[%0d]: got %0d want %0d", i, ShiftCnt, i + 1);
            end
            checks++;
            if (Done !== (i == 5)) begin
                errors++; $display("FAIL up_done[%0d]: got %b want %b", i, Done, i == 5);
            end
        end
        Mode = 2'b00;
        checks++;
        if (Q !== 6'b101100) begin
            errors++; $display("FAIL up_q: got %b want 101100", Q);
        end
        checks++;
        if (SO_UP !== 1'b1) begin
            errors++; $display("FAIL up_so: got %b want 1", SO_UP);
        end
    endtask

    task automatic test_parallel_down();
        logic [5:0] exp_so;
        exp_so = 6'b100101;
        Mode = 2'b11; D = 6'b100101;
        tick();
        checks++;
        if (Q !== 6'b100101 || ShiftCnt !== 3'd0 || Done !== 1'b0) begin
            errors++; $display("FAIL dn_load: got q=%b cnt=%0d done=%b want q=100101 cnt=0 done=0", Q, ShiftCnt, Done);
        end
        Mode = 2'b10; SI_DN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (SO_DN !== exp_so[i]) begin
                errors++; $display("FAIL dn_so[%0d]: got %b want %b", i, SO_DN, exp_so[i]);
            end
            tick();
        end
        Mode = 2'b00;
        checks++;
        if (Q !== 6'h00) begin
            errors++; $display("FAIL dn_q: got %b want 000000", Q);
        end
        checks++;
        if (Done !== 1'b1 || ShiftCnt !== 3'd6) begin
            errors++; $display("FAIL dn_done: got done=%b cnt=%0d want done=1 cnt=6", Done, ShiftCnt);
        end
    endtask

    task automatic test_saturation();
        Mode = 2'b01; SI_UP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ShiftCnt !== 3'd6 || Done !== 1'b1) begin
                errors++; $display("FAIL sat[%0d]: got cnt=%0d done=%b want cnt=6 done=1", i, ShiftCnt, Done);
            end
        end
        checks++;
        if (Q !== 6'b000111) begin
            errors++; $display("FAIL sat_q: got %b want 000111", Q);
        end
        Mode = 2'b11; D = 6'h2A;
        tick();
        Mode = 2'b00;
        checks++;
        if (Q !== 6'h2A || ShiftCnt !== 3'd0 || Done !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got q=%h cnt=%0d done=%b want q=2a cnt=0 done=0", Q, ShiftCnt, Done);
        end
    endtask

    task automatic test_enable();
        Enable = 1'b0; Mode = 2'b11; D = 6'h15;
        tick();
        checks++;
        if (Q !== 6'h2A || ShiftCnt !== 3'd0) begin
            errors++; $display("FAIL en_load: got q=%h cnt=%0d want q=2a cnt=0", Q, ShiftCnt);
        end
        Mode = 2'b01; SI_UP = 1'b1;
        tick();
        checks++;
        if (Q !== 6'h2A || ShiftCnt !== 3'd0) begin
            errors++; $display("FAIL en_shift: got q=%h cnt=%0d want q=2a cnt=0", Q, ShiftCnt);
        end
        Enable = 1'b1; Mode = 2'b11;
        tick();
        checks++;
        if (Q !== 6'h15) begin
            errors++; $display("FAIL en_on: got %h want 15", Q);
        end
        Mode = 2'b00; D = 6'h3F;
        tick();
        checks++;
        if (Q !== 6'h15 || ShiftCnt !== 3'd0) begin
            errors++; $display("FAIL hold: got q=%h cnt=%0d want q=15 cnt=0", Q, ShiftCnt);
        end
    endtask

    task automatic test_mixed();
        Mode = 2'b11; D = 6'b000001;
        tick();
        Mode = 2'b01; SI_UP = 1'b0;
        tick();
        tick();
        checks++;
        if (Q !== 6'b000100) begin
            errors++; $display("FAIL mix_up: got %b want 000100", Q);
        end
        Mode = 2'b10; SI_DN = 1'b0;
        tick();
        checks++;
        if (Q !== 6'b000010 || ShiftCnt !== 3'd3) begin
            errors++; $display("FAIL mix_dn: got q=%b cnt=%0d want q=000010 cnt=3", Q, ShiftCnt);
        end
        Reset = 1'b1; Mode = 2'b01; SI_UP = 1'b1;
        tick();
        checks++;
        if (Q !== 6'h00 || ShiftCnt !== 3'd0 || Done !== 1'b0) begin
            errors++; $display("FAIL mix_rst: got q=%b cnt=%0d done=%b want 0/0/0", Q, ShiftCnt, Done);
        end
        Reset = 1'b0; Mode = 2'b11; D = 6'h3F;
        tick();
        Enable = 1'b0; Reset = 1'b1;
        tick();
        Reset = 1'b0; Enable = 1'b1; Mode = 2'b00;
        checks++;
        if (Q !== 6'h00 || ShiftCnt !== 3'd0) begin
            errors++; $display("FAIL rst_noen: got q=%h cnt=%0d want q=00 cnt=0", Q, ShiftCnt);
        end
    endtask

    initial begin
        Reset = 1'b0; Enable = 1'b0; Mode = 2'b00;
        SI_UP = 1'b0; SI_DN = 1'b0; D = '0;
        test_reset();
        test_serial_up();
        test_parallel_down();
        test_saturation();
        test_enable();
        test_mixed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
